// File: rtl/gated_hit_counter.sv
// gated_hit_counter
// Counts rising edges of an asynchronous detector HIT input inside a
// synchronous GATE window and presents one result per completed gate
// through a VALID/READY handshake. Results that arrive while an earlier
// one is still unconsumed are dropped and counted in DROPPED.
// Optional feature: define GATED_HIT_COUNTER_TSTAMP_EN to add the TSTAMP
// output (cycles from gate start to the first counted hit).
module gated_hit_counter #(
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   GATE,
  input  logic                   HIT,
  output logic [COUNT_WIDTH-1:0] COUNT,
  output logic                   OVERFLOW,
  output logic                   VALID,
  input  logic                   READY,
  output logic [7:0]             DROPPED
`ifdef GATED_HIT_COUNTER_TSTAMP_EN
  ,
  output logic [15:0]            TSTAMP
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] ACC_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] ACC_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state;
  state_t                   state_next;
  logic [SYNC_STAGES-1:0]   hit_sync;
  logic                     hit_prev;
  logic                     hit_event;
  logic                     gate_d;
  logic                     gate_start;
  logic                     gate_end;
  logic                     transfer;
  logic                     count_en;
  logic [COUNT_WIDTH-1:0]   acc;
  logic                     acc_ovf;

  // Saturating 8-bit increment used for the drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    if (val == 8'hFF) begin
      sat_inc8 = 8'hFF;
    end else begin
      sat_inc8 = val + 8'd1;
    end
  endfunction

  // Bring HIT into the CLK domain and keep one extra flop for edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_sync <= {SYNC_STAGES{1'b0}};
      hit_prev <= 1'b0;
    end else begin
      hit_sync <= {hit_sync[SYNC_STAGES-2:0], HIT};
      hit_prev <= hit_sync[SYNC_STAGES-1];
    end
  end

  // Delayed GATE; resets high so a gate already open at release is ignored.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      gate_d <= 1'b1;
    end else begin
      gate_d <= GATE;
    end
  end

  assign hit_event  = hit_sync[SYNC_STAGES-1] & ~hit_prev;
  assign gate_start = GATE & ~gate_d;
  assign gate_end   = ~GATE & gate_d;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; a gate end seen while idle is ignored.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (gate_start) begin
          state_next = ST_COUNT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (gate_end) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_COUNT;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: result transfer on gate end, counting while the gate is open.
  always_comb begin
    transfer = 1'b0;
    count_en = 1'b0;
    case (state)
      ST_IDLE: begin
        transfer = 1'b0;
        count_en = 1'b0;
      end
      ST_COUNT: begin
        transfer = gate_end;
        count_en = GATE & hit_event;
      end
      default: begin
        transfer = 1'b0;
        count_en = 1'b0;
      end
    endcase
  end

  // Hit accumulator: seeded at gate start, saturates and flags overflow.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc     <= {COUNT_WIDTH{1'b0}};
      acc_ovf <= 1'b0;
    end else if (gate_start) begin
      acc     <= hit_event ? ACC_ONE : {COUNT_WIDTH{1'b0}};
      acc_ovf <= 1'b0;
    end else if (count_en) begin
      if (acc == ACC_MAX) begin
        acc_ovf <= 1'b1;
      end else begin
        acc <= acc + ACC_ONE;
      end
    end
  end

  // Result register and handshake; a result arriving on an unconsumed one is dropped.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      COUNT    <= {COUNT_WIDTH{1'b0}};
      OVERFLOW <= 1'b0;
      VALID    <= 1'b0;
      DROPPED  <= 8'd0;
    end else if (transfer) begin
      if (VALID && !READY) begin
        DROPPED <= sat_inc8(DROPPED);
      end else begin
        COUNT    <= acc;
        OVERFLOW <= acc_ovf;
        VALID    <= 1'b1;
      end
    end else if (VALID && READY) begin
      VALID <= 1'b0;
    end
  end

`ifdef GATED_HIT_COUNTER_TSTAMP_EN
  logic [15:0] ts_cyc;
  logic [15:0] ts_first;
  logic        ts_found;

  // Track cycles since gate start and latch the offset of the first counted hit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ts_cyc   <= 16'd0;
      ts_first <= 16'hFFFF;
      ts_found <= 1'b0;
    end else if (gate_start) begin
      ts_cyc   <= 16'd1;
      ts_found <= hit_event;
      ts_first <= hit_event ? 16'd0 : 16'hFFFF;
    end else if (state == ST_COUNT && GATE) begin
      if (ts_cyc != 16'hFFFF) begin
        ts_cyc <= ts_cyc + 16'd1;
      end
      if (hit_event && !ts_found) begin
        ts_first <= ts_cyc;
        ts_found <= 1'b1;
      end
    end
  end

  // Timestamp output follows the same load/hold rules as COUNT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      TSTAMP <= 16'd0;
    end else if (transfer && !(VALID && !READY)) begin
      TSTAMP <= ts_first;
    end
  end
`endif

endmodule

// File: tb/tb_gated_hit_counter.sv
// Directed bench for gated_hit_counter: a default-width instance and a
// 4-bit instance share all stimulus so saturation can be seen side by side.
module tb_gated_hit_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        gate;
  logic        hit;
  logic        ready;
  logic [15:0] count;
  logic        overflow;
  logic        valid;
  logic [7:0]  dropped;
  logic [3:0]  count4;
  logic        overflow4;
  logic        valid4;
  logic [7:0]  dropped4;
`ifdef GATED_HIT_COUNTER_TSTAMP_EN
  logic [15:0] tstamp;
  logic [15:0] tstamp4;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #33 clk = ~clk;

  gated_hit_counter dut (
    .CLK(clk), .RESET(reset), .GATE(gate), .HIT(hit),
    .COUNT(count), .OVERFLOW(overflow), .VALID(valid),
    .READY(ready), .DROPPED(dropped)
`ifdef GATED_HIT_COUNTER_TSTAMP_EN
    , .TSTAMP(tstamp)
`endif
  );

  gated_hit_counter #(.COUNT_WIDTH(4)) dut4 (
    .CLK(clk), .RESET(reset), .GATE(gate), .HIT(hit),
    .COUNT(count4), .OVERFLOW(overflow4), .VALID(valid4),
    .READY(ready), .DROPPED(dropped4)
`ifdef GATED_HIT_COUNTER_TSTAMP_EN
    , .TSTAMP(tstamp4)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs, let the next rising edge sample them, settle 1 time unit.
  task automatic step(input logic g, input logic h);
    gate = g;
    hit  = h;
    @(posedge clk);
    #1;
  endtask

  // Gate of len cycles with nhits 3-cycle HIT pulses starting at offset first,
  // spaced by period; then one GATE-low cycle (the gate-end edge).
  task automatic run_gate(input int len, input int nhits, input int first, input int period);
    for (int i = 0; i < len; i++) begin
      logic h;
      h = (i >= first) && (((i - first) % period) < 3) && (((i - first) / period) < nhits);
      step(1'b1, h);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic consume(input string tag);
    ready = 1'b1;
    step(1'b0, 1'b0);
    check_eq({tag, "_valid_cleared"}, {31'd0, valid}, 32'd0);
    ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    gate  = 1'b0;
    hit   = 1'b0;
    ready = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("rst_count", {16'd0, count}, 32'd0);
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_dropped", {24'd0, dropped}, 32'd0);
`ifdef GATED_HIT_COUNTER_TSTAMP_EN
    check_eq("rst_tstamp", {16'd0, tstamp}, 32'd0);
`endif
    reset = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // 86-cycle gate, 5 clean pulses; events at offsets 12,24,36,48,60
    run_gate(86, 5, 10, 12);
    check_eq("g86_valid", {31'd0, valid}, 32'd1);
    check_eq("g86_count", {16'd0, count}, 32'd5);
    check_eq("g86_ovf", {31'd0, overflow}, 32'd0);
`ifdef GATED_HIT_COUNTER_TSTAMP_EN
    check_eq("g86_tstamp", {16'd0, tstamp}, 32'd12);
`endif
    consume("g86");

    // 20 hits: full width counts them, 4-bit instance saturates
    run_gate(130, 20, 2, 6);
    check_eq("h20_count16", {16'd0, count}, 32'd20);
    check_eq("h20_ovf16", {31'd0, overflow}, 32'd0);
    check_eq("h20_count4", {28'd0, count4}, 32'd15);
    check_eq("h20_ovf4", {31'd0, overflow4}, 32'd1);
    consume("h20");
    run_gate(20, 2, 3, 6);
    check_eq("h2_count4", {28'd0, count4}, 32'd2);
    check_eq("h2_ovf4", {31'd0, overflow4}, 32'd0);
    consume("h2");

    // Backpressure over three gates of 1, 2, 3 hits
    run_gate(10, 1, 2, 6);
    check_eq("bp1_count", {16'd0, count}, 32'd1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    run_gate(16, 2, 2, 6);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    run_gate(22, 3, 2, 6);
    check_eq("bp_count_held", {16'd0, count}, 32'd1);
    check_eq("bp_valid", {31'd0, valid}, 32'd1);
    check_eq("bp_dropped", {24'd0, dropped}, 32'd2);
    check_eq("bp_dropped4", {24'd0, dropped4}, 32'd2);
    consume("bp");

    // Reset mid-gate with GATE still high: that gate yields nothing
    for (int i = 0; i < 10; i++) step(1'b1, (i >= 2) && (i < 5));
    reset = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1, (i >= 3) && (i < 6));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("rmid_valid", {31'd0, valid}, 32'd0);
    check_eq("rmid_dropped", {24'd0, dropped}, 32'd0);
    run_gate(30, 4, 3, 6);
    check_eq("rmid_next_count", {16'd0, count}, 32'd4);
    consume("rmid");

    // HIT high before gate start and held through the gate: nothing counted
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check_eq("hold_valid", {31'd0, valid}, 32'd1);
    check_eq("hold_count", {16'd0, count}, 32'd0);
`ifdef GATED_HIT_COUNTER_TSTAMP_EN
    check_eq("hold_tstamp", {16'd0, tstamp}, 32'h0000FFFF);
`endif
    consume("hold");
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Event at offset 7 counted; event on the gate-end edge not counted
    run_gate(20, 2, 5, 13);
    check_eq("gend_count", {16'd0, count}, 32'd1);
`ifdef GATED_HIT_COUNTER_TSTAMP_EN
    check_eq("ts7_tstamp", {16'd0, tstamp}, 32'd7);
`endif
    consume("gend");

    // 1-cycle gate with a hit event on the start cycle
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check_eq("g1_hit_valid", {31'd0, valid}, 32'd1);
    check_eq("g1_hit_count", {16'd0, count}, 32'd1);
`ifdef GATED_HIT_COUNTER_TSTAMP_EN
    check_eq("g1_hit_tstamp", {16'd0, tstamp}, 32'd0);
`endif
    consume("g1_hit");

    // 1-cycle gate with no hit
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("g1_nohit_valid", {31'd0, valid}, 32'd1);
    check_eq("g1_nohit_count", {16'd0, count}, 32'd0);
`ifdef GATED_HIT_COUNTER_TSTAMP_EN
    check_eq("g1_nohit_tstamp", {16'd0, tstamp}, 32'h0000FFFF);
`endif
    consume("g1_nohit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gated_hit_counter.md
GATED_HIT_COUNTER -- requirements
Module: gated_hit_counter

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16: hit accumulator and COUNT output width.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: HIT synchroniser depth, legal range 2..4.
REQ-003 SHALL have port CLK  input  1  15 MHz system clock; all logic on posedge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port GATE  input  1  counting window from the pulse generator, synchronous to CLK.
REQ-006 SHALL have port HIT  input  1  asynchronous detector discriminator output.
REQ-007 SHALL have port COUNT  output  COUNT_WIDTH  hits counted in the last completed gate.
REQ-008 SHALL have port OVERFLOW  output  1  the last completed gate saturated the accumulator.
REQ-009 SHALL have port VALID  output  1  COUNT/OVERFLOW hold an unconsumed result.
REQ-010 SHALL have port READY  input  1  consumer accepts the result when VALID and READY are both high.
REQ-011 SHALL have port DROPPED  output  8  count of results lost to backpressure, saturating.

Function
REQ-012 SHALL pass HIT through SYNC_STAGES flops; hit event = synchronised HIT high and its previous registered value low (rising edge only).
REQ-013 SHALL register GATE into gate_d; gate start = GATE&~gate_d; gate end = ~GATE&gate_d.
REQ-014 SHALL implement states IDLE and COUNT; IDLE->COUNT on gate start; COUNT->IDLE on gate end; otherwise hold.
REQ-015 SHALL on the gate-start cycle load the accumulator with 1 if a hit event is present, else 0, and clear the overflow flag.
REQ-016 SHALL in COUNT, with GATE high, increment the accumulator by 1 per hit event; a hit event on the gate-end cycle is not counted.
REQ-017 SHALL saturate the accumulator at 2^COUNT_WIDTH-1; a hit event at saturation sets the overflow flag; no wrap-around.
REQ-018 SHALL on the gate-end edge in COUNT transfer accumulator/flag to COUNT/OVERFLOW and set VALID; VALID is high the cycle after GATE is first low.
REQ-019 SHALL clear VALID on a cycle with VALID&READY unless a transfer occurs in the same cycle, in which case the new result loads and VALID stays high.
REQ-020 SHALL when a transfer occurs with VALID high and READY low, keep COUNT/OVERFLOW unchanged and increment DROPPED, saturating at 255.
REQ-021 SHALL treat a 1-cycle GATE as a valid gate: start and end on consecutive cycles; the result is 0 or 1.
REQ-022 SHALL ignore gate-end in IDLE.
REQ-023 SHALL hold COUNT, OVERFLOW stable while VALID is high and no transfer occurs.

Reset
REQ-024 SHALL on RESET set COUNT=0, OVERFLOW=0, VALID=0, DROPPED=0, accumulator=0, state=IDLE, synchroniser and edge flops=0.
REQ-025 SHALL reset gate_d to 1 so a gate already high at reset release is not counted; counting resumes at the next gate start.
REQ-026 SHALL discard any partial gate when RESET is asserted mid-gate; no result is emitted for it.
REQ-027 SHALL give RESET priority over all other events in the same cycle.

Configuration
REQ-028 SHALL with GATED_HIT_COUNTER_TSTAMP_EN defined, add port TSTAMP  output  16: cycles from gate start to the first counted hit (0 if the hit is on the start cycle), 16'hFFFF if no hit; saturating; loaded and held alongside COUNT; reset to 0.
REQ-029 SHALL without GATED_HIT_COUNTER_TSTAMP_EN, omit the TSTAMP port and its logic entirely; all other behaviour is identical.

Verification
REQ-030 SHALL cover: GATE high 86 cycles, 5 clean HIT pulses (each 3 cycles wide) inside -> VALID=1 one cycle after GATE falls, COUNT=5, OVERFLOW=0; READY=1 -> VALID=0 next cycle.
REQ-031 SHALL cover: COUNT_WIDTH=4, 20 hits in one gate -> COUNT=15, OVERFLOW=1; next gate with 2 hits -> COUNT=2, OVERFLOW=0.
REQ-032 SHALL cover: READY held 0 over three gates of 1, 2 and 3 hits -> COUNT=1, DROPPED=2; READY=1 -> consumed, VALID=0.
REQ-033 SHALL cover: RESET asserted 10 cycles into a gate with GATE still high, released mid-gate -> no VALID for that gate; next gate with 4 hits -> COUNT=4.
REQ-034 SHALL cover: HIT held high across the whole gate -> COUNT=0 if HIT rose before gate start; a hit event on the gate-end cycle -> not counted.
REQ-035 SHALL cover, with GATED_HIT_COUNTER_TSTAMP_EN defined: first hit event 7 cycles after gate start -> TSTAMP=7; gate with no hits -> TSTAMP=16'hFFFF.
